// File: rtl/clock_ratio_meter.sv
// Measures the period and high time of a slow asynchronous signal in clk_in cycles.
// Define CLKMETER_DUTY_EN to build the high-time counter and include it in the lock test.
module clock_ratio_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        sig_in,
  input  logic        enable,
  output logic [31:0] ratio,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync;
  logic                   s_prev;
  logic                   rise;
  logic [31:0]            per_cnt;
  logic [31:0]            per_inc;
  logic                   expired;
  logic                   have_prev;
  logic                   ratio_match;
`ifdef CLKMETER_DUTY_EN
  logic [31:0]            hi_cnt;
`endif

  assign s_sync  = sync[SYNC_STAGES-1];
  assign rise    = s_sync & ~s_prev;
  assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 32'd1;
  assign expired = (per_cnt >= TIMEOUT);

`ifdef CLKMETER_DUTY_EN
  assign ratio_match = (per_cnt == ratio) && (hi_cnt == high_time);
`else
  assign ratio_match = (per_cnt == ratio);
  assign high_time   = '0;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      per_cnt   <= '0;
      ratio     <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      have_prev <= 1'b0;
`ifdef CLKMETER_DUTY_EN
      hi_cnt    <= '0;
      high_time <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state     <= StIdle;
        per_cnt   <= '0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
        have_prev <= 1'b0;
`ifdef CLKMETER_DUTY_EN
        hi_cnt    <= '0;
`endif
      end else begin
        case (state)
          StIdle: state <= StArm;
          StArm: begin
            // First edge only starts the period; no measurement yet.
            if (rise) begin
              state   <= StMeas;
              per_cnt <= 32'd1;
              timeout <= 1'b0;
`ifdef CLKMETER_DUTY_EN
              hi_cnt  <= 32'd1;
`endif
            end else if (expired) begin
              per_cnt <= '0;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              per_cnt <= per_inc;
            end
          end
          StMeas: begin
            if (rise) begin
              ratio     <= per_cnt;
              valid     <= 1'b1;
              locked    <= have_prev && ratio_match;
              have_prev <= 1'b1;
              per_cnt   <= 32'd1;
              timeout   <= 1'b0;
`ifdef CLKMETER_DUTY_EN
              high_time <= hi_cnt;
              hi_cnt    <= 32'd1;
`endif
            end else if (expired) begin
              state     <= StArm;
              per_cnt   <= '0;
              timeout   <= 1'b1;
              locked    <= 1'b0;
              have_prev <= 1'b0;
            end else begin
              per_cnt <= per_inc;
`ifdef CLKMETER_DUTY_EN
              // Low phase leaves hi_cnt frozen until the next rise.
              if (s_sync) hi_cnt <= hi_cnt + 32'd1;
`endif
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
